// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_pkg
//  Description : Shared stopwatch constants: clock rate, default key timing
//                (debounce / long-press / auto-repeat) and key indices, plus
//                the per-channel key event bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

    localparam int CLK_FREQ_MHZ        = 50;
    // 10 ms debounce, 1 s long press, 200 ms auto-repeat at CLK_FREQ_MHZ
    localparam int KEY_DEBOUNCE_CYCLES = CLK_FREQ_MHZ * 10_000;
    localparam int KEY_LONG_CYCLES     = CLK_FREQ_MHZ * 1_000_000;
    localparam int KEY_REPEAT_CYCLES   = CLK_FREQ_MHZ * 200_000;

    localparam int KEY_IDX_RESET       = 0;
    localparam int KEY_IDX_STARTSTOP   = 1;

    // Events produced by one key channel in a given cycle
    typedef struct packed {
        logic level;  // debounced pressed level
        logic press;  // one-cycle press (or auto-repeat) pulse
        logic rls;    // one-cycle release pulse
        logic lng;    // one-cycle long-press pulse
    } key_evt_t;

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce_ch.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce_ch
//  Description : One push-button channel: two-flop synchronizer, debounce
//                counter, hold counter and registered event pulses.
//                Optional auto-repeat of the press pulse when the macro
//                KEY_AUTOREPEAT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debounce_ch
    import timer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = KEY_LONG_CYCLES,
    parameter int REPEAT_CYCLES   = KEY_REPEAT_CYCLES
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     key_n_i,
    output key_evt_t evt_o
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int HW = cnt_width(LONG_CYCLES);
    localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HMAX = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] HPRE = HW'(LONG_CYCLES - 2);

    // Reject configurations the counters cannot honour
    if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES || REPEAT_CYCLES < 1) begin : g_cfg_check
        $error("key_debounce_ch: invalid DEBOUNCE/LONG/REPEAT cycle parameters");
    end

    logic          sync1_q, sync2_q;
    logic          state_q;
    logic [DW-1:0] dcnt_q;
    logic [HW-1:0] hcnt_q;
    logic          press_q, release_q, long_q;
    logic          raw;
    logic          flip;
    logic          repeat_fire;

    assign raw  = ~sync2_q;
    // Debounced state changes on this edge
    assign flip = (raw != state_q) && (dcnt_q == DMAX);

    // Two-flop synchronizer; resets to the released level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: any agreement restarts the count; the state flips on the
    // DEBOUNCE_CYCLES-th consecutive disagreeing cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= 1'b0;
            dcnt_q  <= '0;
        end else if (raw == state_q) begin
            dcnt_q  <= '0;
        end else if (dcnt_q == DMAX) begin
            state_q <= raw;
            dcnt_q  <= '0;
        end else begin
            dcnt_q  <= dcnt_q + 1'b1;
        end
    end

    // Hold counter saturates at LONG_CYCLES-1, so long_pulse fires once per press
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_q <= '0;
            long_q <= 1'b0;
        end else begin
            long_q <= 1'b0;
            if (!state_q) begin
                hcnt_q <= '0;
            end else if (hcnt_q != HMAX) begin
                hcnt_q <= hcnt_q + 1'b1;
                long_q <= (hcnt_q == HPRE);
            end
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam int RW = cnt_width(REPEAT_CYCLES);
    localparam logic [RW-1:0] RMAX = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rcnt_q;

    // A repeat on the releasing edge is suppressed so no pulse trails the release
    assign repeat_fire = state_q && (hcnt_q == HMAX) && (rcnt_q == RMAX) && !flip;

    // Repeat period counter, running only once the hold counter has saturated
    always_ff @(posedge clk) begin
        if (rst || !state_q) begin
            rcnt_q <= '0;
        end else if (hcnt_q == HMAX) begin
            rcnt_q <= (rcnt_q == RMAX) ? '0 : rcnt_q + 1'b1;
        end
    end
`else
    assign repeat_fire = 1'b0;
`endif

    // Press / release pulses registered on the same edge that flips the state
    always_ff @(posedge clk) begin
        if (rst) begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            press_q   <= (flip && raw) || repeat_fire;
            release_q <= flip && !raw;
        end
    end

    assign evt_o.level = state_q;
    assign evt_o.press = press_q;
    assign evt_o.rls   = release_q;
    assign evt_o.lng   = long_q;

endmodule
`default_nettype wire

// File: rtl/key_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : key_conditioner
//  Description : Stopwatch key input stage. Turns raw active-low buttons into
//                debounced levels and one-cycle press/release/long events,
//                one independent key_debounce_ch per key. Auto-repeat of
//                press_pulse is enabled by defining KEY_AUTOREPEAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_conditioner
    import timer_pkg::*;
#(
    parameter int NUM_KEYS        = 2,
    parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = KEY_LONG_CYCLES,
    parameter int REPEAT_CYCLES   = KEY_REPEAT_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic [NUM_KEYS-1:0] long_pulse
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_evt_t evt;

        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .key_n_i (key_n[i]),
            .evt_o   (evt)
        );

        assign key_level[i]     = evt.level;
        assign press_pulse[i]   = evt.press;
        assign release_pulse[i] = evt.rls;
        assign long_pulse[i]    = evt.lng;
    end

endmodule
`default_nettype wire

// File: tb/tb_key_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_conditioner
//  Description : Self-checking bench for key_conditioner with short timing
//                (debounce 4, long 20, repeat 6). A timestamp-based model of
//                the key rules is compared every cycle; directed scenarios
//                pin event edges to hand-computed literals. Honours
//                KEY_AUTOREPEAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_conditioner;

    localparam int D = 4;
    localparam int L = 20;
    localparam int R = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] key_n = 2'b11;
    logic [1:0] key_level, press_pulse, release_pulse, long_pulse;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;   // index of the most recent rising edge

    key_conditioner #(
        .NUM_KEYS        (2),
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L),
        .REPEAT_CYCLES   (R)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .key_n         (key_n),
        .key_level     (key_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: keys seen two edges late; state flips after D
    // consecutive disagreeing samples; long/repeat from press timestamp.
    // ------------------------------------------------------------------
    bit  m_s1 [2];      // pressed flag sampled one edge ago
    bit  m_s2 [2];      // pressed flag sampled two edges ago
    bit  m_st [2];
    int  m_streak [2];
    int  m_press_edge [2];
    logic [1:0] e_lvl = '0, e_prs = '0, e_rel = '0, e_lng = '0;

    task automatic model_step();
        cyc++;
        e_prs = '0; e_rel = '0; e_lng = '0;
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_s1[k] = 1'b0; m_s2[k] = 1'b0;
                m_st[k] = 1'b0; m_streak[k] = 0;
            end
            e_lvl = '0;
            return;
        end
        for (int k = 0; k < 2; k++) begin
            bit raw, was_held, flipped;
            int age;
            raw      = m_s2[k];
            m_s2[k]  = m_s1[k];
            m_s1[k]  = ~key_n[k];
            was_held = m_st[k];
            flipped  = 1'b0;
            m_streak[k] = (raw != m_st[k]) ? m_streak[k] + 1 : 0;
            if (m_streak[k] == D) begin
                flipped     = 1'b1;
                m_st[k]     = raw;
                m_streak[k] = 0;
                if (raw) begin
                    e_prs[k] = 1'b1;
                    m_press_edge[k] = cyc;
                end else begin
                    e_rel[k] = 1'b1;
                end
            end
            if (was_held) begin
                age = cyc - m_press_edge[k];
                if (age == L - 1) e_lng[k] = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
                if (!flipped && age > L - 1 && ((age - (L - 1)) % R) == 0) e_prs[k] = 1'b1;
`endif
            end
            e_lvl[k] = m_st[k];
        end
    endtask

    always @(posedge clk) model_step();

    task automatic chk(input string nm, input int act, input int want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0d want %0d (edge %0d)", nm, act, want, cyc);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("key_level",     int'(key_level),     int'(e_lvl));
            chk("press_pulse",   int'(press_pulse),   int'(e_prs));
            chk("release_pulse", int'(release_pulse), int'(e_rel));
            chk("long_pulse",    int'(long_pulse),    int'(e_lng));
        end
    end

    // ------------------------------------------------------------------
    // Event logs for the directed literal checks
    // ------------------------------------------------------------------
    int p0[$], p1[$], r0[$], r1[$], l0[$], l1[$];
    bit lvl0_seen;

    function automatic int nth(input int q[$], input int i);
        return (q.size() > i) ? q[i] : -1;
    endfunction

    task automatic clear_logs();
        p0.delete(); p1.delete(); r0.delete(); r1.delete(); l0.delete(); l1.delete();
        lvl0_seen = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            if (press_pulse[0])   p0.push_back(cyc);
            if (press_pulse[1])   p1.push_back(cyc);
            if (release_pulse[0]) r0.push_back(cyc);
            if (release_pulse[1]) r1.push_back(cyc);
            if (long_pulse[0])    l0.push_back(cyc);
            if (long_pulse[1])    l1.push_back(cyc);
            if (key_level[0])     lvl0_seen = 1'b1;
        end
    endtask

    int n_edge, r_edge, late;
    int rem [2];

    initial begin
        // Reset state
        rst = 1'b1; key_n = 2'b11;
        step(); step(); step();
        chk("rst_level",   int'(key_level),     0);
        chk("rst_press",   int'(press_pulse),   0);
        chk("rst_release", int'(release_pulse), 0);
        chk("rst_long",    int'(long_pulse),    0);
        rst = 1'b0;
        run(4);

        // 1. Clean press on key 1, held 30 cycles
        clear_logs();
        key_n[1] = 1'b0; n_edge = cyc + 1;
        run(30);
        key_n[1] = 1'b1;
        run(12);
        chk("s1_press_cnt",    p1.size(), 1);
        chk("s1_press_edge",   nth(p1, 0) - n_edge, 5);
        chk("s1_long_edge",    nth(l1, 0) - n_edge, 24);
        chk("s1_release_edge", nth(r1, 0) - n_edge, 35);
        chk("s1_ch0_silent",   p0.size() + r0.size() + l0.size(), 0);

        // 2. Bounce rejection on key 0: 3 low / 3 high for 20 cycles
        clear_logs();
        for (int i = 0; i < 20; i++) begin
            key_n[0] = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
            run(1);
        end
        key_n[0] = 1'b1;
        run(10);
        chk("s2_no_pulses", p0.size() + r0.size() + l0.size(), 0);
        chk("s2_level_low", int'(lvl0_seen), 0);

        // 3. Short press then release on key 0
        clear_logs();
        key_n[0] = 1'b0; n_edge = cyc + 1;
        run(10);
        key_n[0] = 1'b1; r_edge = cyc + 1;
        run(12);
        chk("s3_press_cnt",    p0.size(), 1);
        chk("s3_press_edge",   nth(p0, 0) - n_edge, 5);
        chk("s3_release_cnt",  r0.size(), 1);
        chk("s3_release_edge", nth(r0, 0) - r_edge, 5);
        chk("s3_no_long",      l0.size(), 0);

        // 4. Reset two cycles into the debounce window, key kept low
        clear_logs();
        key_n[0] = 1'b0;
        run(2);
        rst = 1'b1;
        step();
        chk("s4_rst_outputs", int'({key_level, press_pulse, release_pulse, long_pulse}), 0);
        rst = 1'b0; n_edge = cyc + 1;
        run(12);
        chk("s4_press_cnt",  p0.size(), 1);
        chk("s4_press_edge", nth(p0, 0) - n_edge, 5);
        key_n[0] = 1'b1;
        run(12);

        // 5. Both keys pressed on the same edge
        clear_logs();
        key_n = 2'b00; n_edge = cyc + 1;
        run(10);
        key_n = 2'b11;
        run(12);
        chk("s5_press_cnt0", p0.size(), 1);
        chk("s5_press_cnt1", p1.size(), 1);
        chk("s5_same_edge",  nth(p0, 0) - nth(p1, 0), 0);
        chk("s5_press_edge", nth(p0, 0) - n_edge, 5);

        // 6. Held 40 cycles: auto-repeat behaviour
        clear_logs();
        key_n[1] = 1'b0; n_edge = cyc + 1;
        run(40);
        key_n[1] = 1'b1;
        run(14);
        chk("s6_release_edge", nth(r1, 0) - n_edge, 45);
        chk("s6_press_first",  nth(p1, 0) - n_edge, 5);
`ifdef KEY_AUTOREPEAT_EN
        chk("s6_repeat1", nth(p1, 1) - n_edge, 30);
        chk("s6_repeat2", nth(p1, 2) - n_edge, 36);
        late = 0;
        foreach (p1[i]) if (p1[i] >= nth(r1, 0)) late++;
        chk("s6_none_after_release", late, 0);
`else
        chk("s6_single_press", p1.size(), 1);
`endif

        // Randomized phase: random run lengths per key, occasional reset
        rem[0] = 1; rem[1] = 1;
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < 2; k++) begin
                rem[k]--;
                if (rem[k] <= 0) begin
                    key_n[k] = ~key_n[k];
                    rem[k]   = int'($urandom_range(1, 30));
                end
            end
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0; key_n = 2'b11;
        run(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
